bsr_block_fetch: RTL and testbench
==================================

BSR_BLOCK_FETCH -- requirements
Module: bsr_block_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of row_ptr/col_idx read addresses.
REQ-002 SHALL have parameter BLOCK_WORDS, default 16: 32-bit words per 8x8 INT8 block.
REQ-003 SHALL have parameter BLK_AW, default 21: block word-address width.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse launching a layer walk.
REQ-007 num_block_rows  input  16  block rows to walk; sampled on accepted start.
REQ-008 num_block_cols  input  16  col_idx bound; sampled on accepted start.
REQ-009 busy / done / error  output  1 each  walk active / one-cycle completion pulse / sticky fault.
REQ-010 row_ptr_re, row_ptr_raddr[ADDR_WIDTH], row_ptr_rdata[32]  out/out/in  row_ptr BRAM read port.
REQ-011 col_idx_re, col_idx_raddr[ADDR_WIDTH], col_idx_rdata[16]  out/out/in  col_idx BRAM read port.
REQ-012 block_re, block_raddr[BLK_AW], block_rdata[32]  out/out/in  block BRAM read port.
REQ-013 out_valid, out_ready, out_data[32]  out/in/out  block word stream, valid/ready.
REQ-014 out_row[16], out_col[16], out_word[4], out_last_word  output  tags qualifying out_data.
REQ-015 blocks_fetched[32], stall_cycles[32]  output  completed-block count, perf counter.

Function
REQ-016 All three BRAMs SHALL be treated as 1-cycle synchronous read: rdata valid the cycle after re.
REQ-017 FSM states: IDLE, RP_LO, RP_HI, ROW_CHK, CI_RD, BLK_RD, BLK_WAIT, DONE.
REQ-018 start SHALL be accepted only in IDLE; ignored while busy.
REQ-019 busy SHALL rise the cycle after accepted start and fall in the cycle done pulses.
REQ-020 num_block_rows=0: IDLE->DONE directly, done pulses 2 cycles after start, no reads issued.
REQ-021 Per row r: read row_ptr[r] (RP_LO), row_ptr[r+1] (RP_HI); blocks k in [row_ptr[r], row_ptr[r+1]).
REQ-022 Empty row (equal pointers) SHALL advance to next row with no col_idx/block reads.
REQ-023 row_ptr[r+1] < row_ptr[r] SHALL set error, abort to DONE, pulse done; no further reads.
REQ-024 Per block k: read col_idx[k]; col_idx >= num_block_cols SHALL set error and abort as REQ-023.
REQ-025 Block word w SHALL be read at block_raddr = k*BLOCK_WORDS + w, w = 0..BLOCK_WORDS-1, in order.
REQ-026 At most one block read in flight; next read issued only when out holding register is empty or accepted that cycle.
REQ-027 Steady-state throughput with out_ready held high: one word per 2 cycles.
REQ-028 out_data and tags SHALL hold stable while out_valid && !out_ready.
REQ-029 out_last_word SHALL be 1 when out_word = BLOCK_WORDS-1.
REQ-030 blocks_fetched SHALL increment on handshake of out_last_word word; cleared on accepted start.
REQ-031 error SHALL be cleared only by reset or accepted start.

Reset
REQ-032 Asynchronous rst_n assertion SHALL force IDLE, all outputs 0, counters 0, in-flight read discarded, including mid-walk.
REQ-033 First start SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro BSR_FETCH_PERF_EN defined: stall_cycles counts cycles with out_valid && !out_ready, cleared on accepted start, saturating at all-ones.
REQ-035 BSR_FETCH_PERF_EN undefined: stall_cycles tied to 0, no counter logic.

Structure
REQ-036 Shared package bsr_pkg SHALL hold BLOCK_WORDS, the fetch state enum and the row/col/address width constants.
REQ-037 No sub-module; holding register and FSM SHALL be in bsr_block_fetch.

Verification
REQ-038 rows=3, cols=2, row_ptr={0,1,1,3}, col_idx={1,0,1}, block word = k*16+w -> 48 words out; (row,col) tags (0,1),(2,0),(2,1); done once; blocks_fetched=3.
REQ-039 Same layer, out_ready toggling 1-of-3 -> identical word sequence, stable data during stalls, stall_cycles nonzero with BSR_FETCH_PERF_EN, 0 without.
REQ-040 row_ptr={2,1} -> error=1, done pulse, no col_idx_re asserted.
REQ-041 col_idx[0]=5 with cols=4 -> error=1, no block_re for that block, done pulse.
REQ-042 rows=0 start -> done 2 cycles after start, no BRAM reads; start pulsed during busy ignored.
REQ-043 rst_n asserted mid-block -> outputs 0 immediately; fresh start replays layer from word 0.

Source files
------------

// File: rtl/bsr_pkg.sv
// Shared definitions for the BSR block fetcher.
//   BLOCK_WORDS   : 32-bit words per 8x8 INT8 block
//   ROW_W/COL_W   : width of block-row / block-column indices and tags
//   WORD_W        : width of the word-within-block tag
//   PTR_W         : width of a row_ptr entry (block index)
//   fetch_state_e : walk FSM state encoding
package bsr_pkg;
  localparam int BLOCK_WORDS = 16;
  localparam int ROW_W       = 16;
  localparam int COL_W       = 16;
  localparam int WORD_W      = 4;
  localparam int PTR_W       = 32;

  typedef enum logic [2:0] {
    IDLE, RP_LO, RP_HI, ROW_CHK, CI_RD, BLK_RD, BLK_WAIT, DONE
  } fetch_state_e;
endpackage

// File: rtl/bsr_block_fetch.sv
// Walks a BSR-encoded sparse layer: for each block row reads the row_ptr
// pair, for each block in the row reads its col_idx, then streams the
// block's BLOCK_WORDS words out through a one-entry valid/ready holding
// register, tagged with (row, col, word).
// Ports:
//   clk, rst_n (async, active low), start, num_block_rows, num_block_cols
//   busy / done (1-cycle pulse) / error (sticky until start or reset)
//   row_ptr_*, col_idx_*, block_* : 1-cycle synchronous BRAM read ports
//   out_valid/out_ready/out_data + out_row/out_col/out_word/out_last_word
//   blocks_fetched, stall_cycles : completed-block count, stall counter
// Build option: define BSR_FETCH_PERF_EN to enable the stall_cycles
// counter; otherwise stall_cycles is tied to zero.
module bsr_block_fetch
  import bsr_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = bsr_pkg::BLOCK_WORDS,
  parameter int BLK_AW      = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROW_W-1:0]      num_block_rows,
  input  logic [COL_W-1:0]      num_block_cols,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  row_ptr_re,
  output logic [ADDR_WIDTH-1:0] row_ptr_raddr,
  input  logic [31:0]           row_ptr_rdata,
  output logic                  col_idx_re,
  output logic [ADDR_WIDTH-1:0] col_idx_raddr,
  input  logic [15:0]           col_idx_rdata,
  output logic                  block_re,
  output logic [BLK_AW-1:0]     block_raddr,
  input  logic [31:0]           block_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col,
  output logic [WORD_W-1:0]     out_word,
  output logic                  out_last_word,
  output logic [31:0]           blocks_fetched,
  output logic [31:0]           stall_cycles
);
  localparam logic [WORD_W-1:0] LAST_W = WORD_W'(BLOCK_WORDS - 1);

  fetch_state_e      state_q, state_d;
  logic [ROW_W-1:0]  rows_q, row_q, row_d;
  logic [COL_W-1:0]  cols_q, col_q, col_d;
  logic [PTR_W-1:0]  k_q, k_d, end_q, end_d;
  logic [WORD_W-1:0] w_q, w_d;
  logic              ci_new_q, ci_new_d;
  logic              busy_q, done_q, error_q;
  logic              ov_q, last_q;
  logic [31:0]       od_q, blocks_q;
  logic [ROW_W-1:0]  orow_q;
  logic [COL_W-1:0]  ocol_q;
  logic [WORD_W-1:0] oword_q;

  logic accept, finish, err_set, load_hold, row_adv, rp_hi;
  logic hs, hold_free, row_last, bad_col;

  assign hs        = ov_q & out_ready;
  // Holding register can take a new word next cycle if empty or draining now.
  assign hold_free = ~ov_q | out_ready;
  assign row_last  = ({1'b0, row_q} + 17'd1) >= {1'b0, rows_q};
  // col_idx_rdata is only valid in the first BLK_RD cycle after CI_RD.
  assign bad_col   = ci_new_q & (col_idx_rdata >= cols_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    end_d      = end_q;
    w_d        = w_q;
    ci_new_d   = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    err_set    = 1'b0;
    load_hold  = 1'b0;
    row_adv    = 1'b0;
    rp_hi      = 1'b0;
    row_ptr_re = 1'b0;
    col_idx_re = 1'b0;
    block_re   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        row_d   = '0;
        state_d = (num_block_rows == '0) ? DONE : RP_LO;
      end
      RP_LO: begin
        row_ptr_re = 1'b1;
        state_d    = RP_HI;
      end
      RP_HI: begin
        row_ptr_re = 1'b1;
        rp_hi      = 1'b1;
        k_d        = row_ptr_rdata;       // row_ptr[r]
        state_d    = ROW_CHK;
      end
      ROW_CHK: begin
        end_d = row_ptr_rdata;            // row_ptr[r+1]
        if (row_ptr_rdata < k_q) begin
          err_set = 1'b1;
          state_d = DONE;
        end else if (row_ptr_rdata == k_q) row_adv = 1'b1;
        else state_d = CI_RD;
      end
      CI_RD: begin
        col_idx_re = 1'b1;
        w_d        = '0;
        ci_new_d   = 1'b1;
        state_d    = BLK_RD;
      end
      BLK_RD: begin
        if (ci_new_q) col_d = col_idx_rdata;
        if (bad_col) begin
          err_set = 1'b1;
          state_d = DONE;
        end else if (hold_free) begin
          block_re = 1'b1;
          state_d  = BLK_WAIT;
        end
      end
      BLK_WAIT: begin
        load_hold = 1'b1;
        if (w_q != LAST_W) begin
          w_d     = w_q + 1'b1;
          state_d = BLK_RD;
        end else if ((k_q + 32'd1) < end_q) begin
          k_d     = k_q + 32'd1;
          state_d = CI_RD;
        end else row_adv = 1'b1;
      end
      DONE: if (hold_free) begin          // drain the last word before done
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (row_adv) begin
      if (row_last) state_d = DONE;
      else begin
        row_d   = row_q + 1'b1;
        state_d = RP_LO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      end_q    <= '0;
      w_q      <= '0;
      ci_new_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      orow_q   <= '0;
      ocol_q   <= '0;
      oword_q  <= '0;
      last_q   <= 1'b0;
      blocks_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      end_q    <= end_d;
      w_q      <= w_d;
      ci_new_q <= ci_new_d;
      done_q   <= finish;
      if (accept) begin
        rows_q   <= num_block_rows;
        cols_q   <= num_block_cols;
        busy_q   <= 1'b1;
        error_q  <= 1'b0;
        blocks_q <= '0;
      end else if (finish) busy_q <= 1'b0;
      if (err_set) error_q <= 1'b1;
      // load_hold only happens with the register empty, so it never
      // collides with a handshake.
      if (load_hold) begin
        ov_q    <= 1'b1;
        od_q    <= block_rdata;
        orow_q  <= row_q;
        ocol_q  <= col_q;
        oword_q <= w_q;
        last_q  <= (w_q == LAST_W);
      end else if (hs) ov_q <= 1'b0;
      if (hs && last_q) blocks_q <= blocks_q + 32'd1;
    end
  end

`ifdef BSR_FETCH_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (accept) stall_q <= '0;
    else if (ov_q && !out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign row_ptr_raddr  = ADDR_WIDTH'({16'b0, row_q} + (rp_hi ? 32'd1 : 32'd0));
  assign col_idx_raddr  = ADDR_WIDTH'(k_q);
  assign block_raddr    = BLK_AW'(k_q * 32'(BLOCK_WORDS) + 32'(w_q));
  assign out_valid      = ov_q;
  assign out_data       = od_q;
  assign out_row        = orow_q;
  assign out_col        = ocol_q;
  assign out_word       = oword_q;
  assign out_last_word  = last_q;
  assign blocks_fetched = blocks_q;
endmodule

// File: tb/tb_bsr_block_fetch.sv
module tb_bsr_block_fetch;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [15:0] num_block_rows = '0, num_block_cols = '0;
  logic        busy, done, error, row_ptr_re, col_idx_re, block_re;
  logic        out_valid, out_last_word;
  logic [15:0] row_ptr_raddr, col_idx_raddr, out_row, out_col;
  logic [20:0] block_raddr;
  logic [31:0] row_ptr_rdata = '0, block_rdata = '0, out_data, blocks_fetched, stall_cycles;
  logic [15:0] col_idx_rdata = '0;
  logic [3:0]  out_word;

  bsr_block_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_block_rows(num_block_rows), .num_block_cols(num_block_cols),
    .busy(busy), .done(done), .error(error),
    .row_ptr_re(row_ptr_re), .row_ptr_raddr(row_ptr_raddr), .row_ptr_rdata(row_ptr_rdata),
    .col_idx_re(col_idx_re), .col_idx_raddr(col_idx_raddr), .col_idx_rdata(col_idx_rdata),
    .block_re(block_re), .block_raddr(block_raddr), .block_rdata(block_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_word(out_word), .out_last_word(out_last_word),
    .blocks_fetched(blocks_fetched), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // BRAM models: data appears the cycle after re.
  logic [31:0] rp_mem [32];
  logic [15:0] ci_mem [64];
  logic [31:0] blk_mem [1024];
  always @(posedge clk) begin
    if (row_ptr_re) row_ptr_rdata <= rp_mem[row_ptr_raddr[4:0]];
    if (col_idx_re) col_idx_rdata <= ci_mem[col_idx_raddr[5:0]];
    if (block_re)   block_rdata   <= blk_mem[block_raddr[9:0]];
  end

  typedef struct { logic [31:0] d; logic [15:0] r; logic [15:0] c; logic [3:0] w; } exp_t;
  typedef struct { int rows; int cols; int rp[5]; int ci[12]; int rmode; bit poke; bit err; int blocks; } vec_t;

  exp_t exp_q[$];
  int n_checks = 0, n_pass = 0;
  int done_cnt, rp_re_cnt, ci_re_cnt, blk_re_cnt, stall_seen, words_seen;
  int m_rp, m_ci, m_blocks;
  bit m_err;
  int rmode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // out_ready pattern: 0 = always high, 1 = high one cycle in three, 2 = random
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(posedge clk); #1;
      rc++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (rc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: counts reads/done, checks the stream against the model queue
  // and that held words stay stable while stalled.
  initial begin
    exp_t e;
    logic prev_stall;
    logic [31:0] pd;
    logic [35:0] ptag;
    prev_stall = 1'b0; pd = '0; ptag = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (done)       done_cnt++;
        if (row_ptr_re) rp_re_cnt++;
        if (col_idx_re) ci_re_cnt++;
        if (block_re)   blk_re_cnt++;
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, pd);
          chk("hold_tags", {out_row, out_col, out_word}, ptag);
        end
        if (out_valid && out_ready) begin
          words_seen++;
          if (exp_q.size() == 0) chk("extra_word", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("word_data", out_data, e.d);
            chk("word_tags", {out_row, out_col, out_word}, {e.r, e.c, e.w});
            chk("last_word", out_last_word, (e.w == 4'd15));
          end
        end
        if (out_valid && !out_ready) stall_seen++;
        prev_stall = out_valid && !out_ready;
        pd   = out_data;
        ptag = {out_row, out_col, out_word};
      end
    end
  end

  // Reference walk over the CSR-of-blocks structure held in the memories.
  task automatic model(input int rows, input int cols);
    int lo, hi;
    m_err = 0; m_rp = 0; m_ci = 0; m_blocks = 0;
    exp_q.delete();
    for (int r = 0; r < rows && !m_err; r++) begin
      m_rp += 2;
      lo = int'(rp_mem[r]); hi = int'(rp_mem[r+1]);
      if (hi < lo) m_err = 1;
      else for (int k = lo; k < hi && !m_err; k++) begin
        m_ci++;
        if (int'(ci_mem[k]) >= cols) m_err = 1;
        else begin
          for (int w = 0; w < 16; w++)
            exp_q.push_back('{blk_mem[k*16+w], 16'(r), ci_mem[k], 4'(w)});
          m_blocks++;
        end
      end
    end
  endtask

  task automatic start_layer(input vec_t v, input bit rand_data);
    for (int i = 0; i < 32; i++) rp_mem[i] = (i < 5) ? 32'(v.rp[i]) : 32'd0;
    for (int i = 0; i < 64; i++) ci_mem[i] = (i < 12) ? 16'(v.ci[i]) : 16'd0;
    for (int i = 0; i < 1024; i++) blk_mem[i] = rand_data ? $urandom : 32'(i);
    model(v.rows, v.cols);
    rmode = v.rmode;
    done_cnt = 0; rp_re_cnt = 0; ci_re_cnt = 0; blk_re_cnt = 0; stall_seen = 0; words_seen = 0;
    num_block_rows = 16'(v.rows);
    num_block_cols = 16'(v.cols);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_layer(input string nm, input vec_t v, input bit use_tbl, input bit rand_data);
    int t;
    start_layer(v, rand_data);
    if (v.poke) begin                     // start while busy must be ignored
      repeat (6) @(posedge clk);
      #1 num_block_rows = 16'd0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0; num_block_rows = 16'(v.rows);
    end
    t = 0;
    while (done_cnt == 0 && t < 3000) begin @(posedge clk); t++; end
    chk({nm, ":done_timeout"}, (done_cnt > 0), 1);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, ":done_once"}, done_cnt, 1);
    chk({nm, ":busy_after"}, busy, 0);
    chk({nm, ":error"}, error, use_tbl ? v.err : m_err);
    chk({nm, ":blocks_fetched"}, blocks_fetched, use_tbl ? v.blocks : m_blocks);
    chk({nm, ":words_left"}, exp_q.size(), 0);
    chk({nm, ":rp_reads"}, rp_re_cnt, m_rp);
    chk({nm, ":ci_reads"}, ci_re_cnt, m_ci);
    chk({nm, ":blk_reads"}, blk_re_cnt, m_blocks * 16);
`ifdef BSR_FETCH_PERF_EN
    chk({nm, ":stall_cycles"}, stall_cycles, stall_seen);
`else
    chk({nm, ":stall_cycles"}, stall_cycles, 0);
`endif
    if (v.rmode == 1 && m_blocks > 0) chk({nm, ":stalls_seen"}, (stall_seen > 0), 1);
  endtask

  function automatic vec_t mkv(int rows, int cols, int rmode_i, bit poke, bit err, int blocks);
    vec_t v;
    v.rows = rows; v.cols = cols; v.rmode = rmode_i; v.poke = poke; v.err = err; v.blocks = blocks;
    for (int i = 0; i < 5; i++) v.rp[i] = 0;
    for (int i = 0; i < 12; i++) v.ci[i] = 0;
    return v;
  endfunction

  vec_t tbl[6];

  initial begin
    vec_t v;
    int t;
    // {rows, cols, ready mode, poke, expected error, expected blocks}
    tbl[0] = mkv(3, 2, 0, 0, 0, 3);
    tbl[0].rp[1] = 1; tbl[0].rp[2] = 1; tbl[0].rp[3] = 3; tbl[0].ci[0] = 1; tbl[0].ci[2] = 1;
    tbl[1] = tbl[0]; tbl[1].rmode = 1;
    tbl[2] = mkv(1, 2, 0, 0, 1, 0);  tbl[2].rp[0] = 2; tbl[2].rp[1] = 1;
    tbl[3] = mkv(1, 4, 0, 0, 1, 0);  tbl[3].rp[1] = 1; tbl[3].ci[0] = 5;
    tbl[4] = mkv(2, 4, 0, 0, 0, 0);
    tbl[5] = mkv(2, 3, 2, 1, 0, 3);
    tbl[5].rp[1] = 2; tbl[5].rp[2] = 3; tbl[5].ci[0] = 2; tbl[5].ci[2] = 1;

    // reset state
    #22;
    chk("reset_outs", {busy, done, error, out_valid, row_ptr_re, col_idx_re, block_re,
                       blocks_fetched, stall_cycles}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outs", {busy, done, error, out_valid, blocks_fetched}, 0);

    for (int i = 0; i < 6; i++) run_layer($sformatf("tbl%0d", i), tbl[i], 1, 0);

    // rows=0: done two cycles after start, no reads, start during busy ignored
    done_cnt = 0; rp_re_cnt = 0; ci_re_cnt = 0; blk_re_cnt = 0;
    num_block_rows = 16'd0; num_block_cols = 16'd1;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk); chk("rows0_c0", {busy, done}, 2'b00);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("rows0_c1", {busy, done}, 2'b10);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("rows0_c2", {busy, done}, 2'b01);
    @(negedge clk); chk("rows0_c3", {busy, done}, 2'b00);
    repeat (4) @(negedge clk);
    chk("rows0_done_once", done_cnt, 1);
    chk("rows0_no_reads", rp_re_cnt + ci_re_cnt + blk_re_cnt, 0);

    // reset mid-block, then replay the layer from word 0
    start_layer(tbl[0], 0);
    t = 0;
    while (words_seen < 20 && t < 1000) begin @(posedge clk); t++; end
    chk("midrst_reach", (words_seen >= 20), 1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy, done, error, out_valid, row_ptr_re, col_idx_re, block_re,
                        out_data, out_row, out_col, out_word, out_last_word,
                        blocks_fetched, stall_cycles}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_layer("replay", tbl[0], 1, 0);

    // randomized layers against the model
    for (int n = 0; n < 8; n++) begin
      v = mkv(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), 0, 0, 0);
      v.rp[0] = int'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++)
        v.rp[i+1] = ($urandom_range(0, 7) == 0 && v.rp[i] > 0) ? v.rp[i] - 1
                                                              : v.rp[i] + int'($urandom_range(0, 2));
      for (int i = 0; i < 12; i++)
        v.ci[i] = ($urandom_range(0, 9) == 0) ? v.cols : int'($urandom_range(0, v.cols - 1));
      run_layer($sformatf("rand%0d", n), v, 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
